// File: rtl/arb_pkg.sv
// Shared definitions for the image-BRAM port arbiter: requester indices,
// arbiter state encoding and a one-hot helper.
package arb_pkg;
    localparam int NREQ = 3;

    localparam logic [1:0] REQ_UART_WR = 2'd0;
    localparam logic [1:0] REQ_DS      = 2'd1;
    localparam logic [1:0] REQ_UART_RD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot3(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction
endpackage

// File: rtl/rr_pick3.sv
// Next winner among three requesters: first pending index after base (mod 3),
// base itself last. With base tied to 2 this is fixed priority 0 > 1 > 2.
module rr_pick3
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] pend,
    input  logic [1:0]      base,
    output logic [1:0]      win,
    output logic            any
);
    logic [1:0] p1, p2;

    assign p1  = (base == 2'd2) ? 2'd0 : base + 2'd1;
    assign p2  = (p1 == 2'd2)   ? 2'd0 : p1 + 2'd1;
    assign any = |pend;

    always_comb begin
        win = base;
        if (pend[p1])      win = p1;
        else if (pend[p2]) win = p2;
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// Three-master arbiter for the single-port image BRAM with lock, burst cap and
// tagged read return. Define ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2.
module bram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           req,
    input  logic [2:0]           lock,
    input  logic [2:0]           we,
    input  logic [3*ADDR_W-1:0]  addr,
    input  logic [3*DATA_W-1:0]  wdata,
    output logic [2:0]           gnt,
    output logic [2:0]           rvalid,
    output logic [DATA_W-1:0]    rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    input  logic [DATA_W-1:0]    mem_dout
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [1:0]       owner_q, owner_d, last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       gnt_d, others;
    logic [2:0]       pick_pend;
    logic [1:0]       pick_base, pick_win;
    logic             pick_any, acc, release_o;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] din_hold;
    logic [RD_LAT:1]   vld_pipe;
    logic [1:0]        tag_pipe [RD_LAT:1];

    assign others    = req & ~onehot3(owner_q);
    assign acc       = (state_q == OWN) && req[owner_q];
    assign pick_pend = (state_q == IDLE) ? req : others;
`ifdef ARB_FIXED_PRIO_EN
    assign pick_base = 2'd2;
`else
    assign pick_base = (state_q == IDLE) ? last_q : owner_q;
`endif

    rr_pick3 u_pick (
        .pend (pick_pend),
        .base (pick_base),
        .win  (pick_win),
        .any  (pick_any)
    );

    assign release_o = !req[owner_q] || (!lock[owner_q] && (|others) && (cnt_q == CAP));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (pick_any) begin
                state_d = OWN;
                owner_d = pick_win;
                cnt_d   = '0;
            end
            OWN: if (release_o) begin
                last_d = owner_q;
                cnt_d  = '0;
                if (|others) owner_d = pick_win;
                else         state_d = IDLE;
            end else if (cnt_q != CAP) begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == OWN) ? onehot3(owner_d) : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= REQ_UART_RD;
            cnt_q   <= '0;
            gnt     <= 3'b000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
        end
    end

    // Address/data follow the owner while accessing, otherwise hold the last access.
    assign mem_en   = acc;
    assign mem_we   = acc && we[owner_q];
    assign mem_addr = acc ? addr[owner_q*ADDR_W +: ADDR_W]  : addr_hold;
    assign mem_din  = acc ? wdata[owner_q*DATA_W +: DATA_W] : din_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold <= '0;
            din_hold  <= '0;
        end else if (acc) begin
            addr_hold <= mem_addr;
            din_hold  <= mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= 2'd0;
        end else begin
            vld_pipe[1] <= acc && !we[owner_q];
            tag_pipe[1] <= owner_q;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rvalid = vld_pipe[RD_LAT] ? onehot3(tag_pipe[RD_LAT]) : 3'b000;
    assign rdata  = mem_dout;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter: behavioural arbitration model checks
// grants each cycle; a scoreboard queue checks tagged read returns.
module tb_bram_port_arbiter;
    localparam int AW = 16, DW = 8, RL = 2, MB = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [2:0] req = '0, lock = '0, we = '0;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [2:0] gnt, rvalid;
    logic [DW-1:0] rdata, mem_din;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0, r1 = '0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // two-cycle BRAM
    bit [7:0] bram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_din;
            else        r1 <= bram[mem_addr];
        end
        mem_dout <= r1;
    end

    typedef struct { int tag; logic [7:0] data; int due; } rd_t;
    rd_t q[$];
    rd_t e;
    bit [7:0] mmem [0:65535];
    int own = -1, run = 0, last = 2;
    int pcnt = 0;
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [2:0] m, input int base);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) if (m[i]) return i;
`else
        for (int k = 1; k <= 3; k++) if (m[(base + k) % 3]) return (base + k) % 3;
`endif
        return -1;
    endfunction

    function automatic logic [3*AW-1:0] pk_a(input int a0, input int a1, input int a2);
        return {16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [3*DW-1:0] pk_d(input int d0, input int d1, input int d2);
        return {8'(d2), 8'(d1), 8'(d0)};
    endfunction

    // One cycle: check grant, drive inputs, advance the reference model.
    task automatic step(input bit [2:0] r, input bit [2:0] l, input bit [2:0] w,
                        input logic [3*AW-1:0] a, input logic [3*DW-1:0] d);
        int ad;
        bit [2:0] oth;
        @(negedge clk);
        chk("gnt", gnt, (own < 0) ? 3'b000 : 3'(1 << own));
        req = r; lock = l; we = w; addr = a; wdata = d;
        if (own >= 0 && r[own]) begin
            ad = int'(a[own*AW +: AW]);
            if (w[own]) mmem[ad] = d[own*DW +: DW];
            else        q.push_back('{own, mmem[ad], pcnt + RL});
        end
        if (own < 0) begin
            if (r != 0) begin own = pick(r, last); run = 0; end
        end else begin
            oth = r & ~(3'b001 << own);
            if (!r[own] || (!l[own] && oth != 0 && run == MB - 1)) begin
                last = own;
                if (oth != 0) begin own = pick(oth, own); run = 0; end
                else own = -1;
            end else if (run < MB - 1) run++;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        q.delete();
        own = -1; run = 0; last = 2;
        req = '0; lock = '0; we = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Read-return monitor
    always @(posedge clk) begin
        pcnt++;
        #1;
        if (rvalid != 3'b000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rd_spurious: rvalid=%b rdata=%h with nothing outstanding", rvalid, rdata);
            end else begin
                e = q.pop_front();
                if (rvalid != 3'(1 << e.tag) || rdata != e.data || e.due != pcnt) begin
                    errors++;
                    $display("FAIL rd_return: rvalid=%b rdata=%h cyc=%0d expected rvalid=%b rdata=%h cyc=%0d",
                             rvalid, rdata, pcnt, 3'(1 << e.tag), e.data, e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due <= pcnt) begin
            checks++;
            errors++;
            $display("FAIL rd_missing: no rvalid at cyc=%0d expected tag %0d data %h", pcnt, q[0].tag, q[0].data);
            void'(q.pop_front());
        end
    end

    initial begin
        bit [2:0] rr, ll, ww;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs();
        @(negedge clk);
        rst_n = 1'b1;

        // all three contend, unlocked reads
        for (int i = 0; i < 40; i++)
            step(3'b111, 3'b000, 3'b000, pk_a(i % 32, (i + 7) % 32, (i + 3) % 32), '0);
        // reset lands mid-burst with reads in flight
        pulse_reset();

        // locked bulk write by requester 0 while 1 waits
        step(3'b011, 3'b001, 3'b001, pk_a(0, 9, 0), pk_d(8'hA0, 0, 0));
        for (int i = 0; i < 20; i++)
            step(3'b011, 3'b001, 3'b001, pk_a(i, 9, 0), pk_d(8'hA0 + i, 0, 0));
        for (int i = 0; i < 4; i++)
            step(3'b010, 3'b000, 3'b000, pk_a(0, i, 0), '0);

        // requester 2 stores 0x5A at 5, then reads it back under contention
        for (int i = 0; i < 4; i++)
            step(3'b100, 3'b000, 3'b100, pk_a(0, 0, 5), pk_d(0, 0, 8'h5A));
        for (int i = 0; i < 20; i++)
            step(3'b110, 3'b000, 3'b000, pk_a(0, i, 5), '0);
        // read back the bulk-written region
        for (int i = 0; i < 20; i++)
            step(3'b100, 3'b000, 3'b000, pk_a(0, 0, i), '0);

        // lone requester 1 keeps the grant far beyond the burst cap
        for (int i = 0; i < 40; i++)
            step(3'b010, 3'b000, 3'b000, pk_a(0, i % 32, 0), '0);

        // randomized traffic
        rr = 3'b000; ll = 3'b000; ww = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0)  rr[b] = ~rr[b];
                if ($urandom_range(0, 15) == 0) ll[b] = ~ll[b];
                ww[b] = $urandom_range(0, 1) == 1;
            end
            step(rr, ll, ww,
                 pk_a($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)),
                 pk_d($urandom, $urandom, $urandom));
        end

        for (int i = 0; i < 6; i++) step(3'b000, 3'b000, 3'b000, '0, '0);
        chk("rd_outstanding", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port 64K x 8 image BRAM among three masters: UART byte writer (req 0), downsampling core (req 1), UART result reader (req 2).
- Round-robin, with per-requester lock for bulk transfers and a burst cap for unlocked owners.
- Returns read data to the requester that issued the read, tagged through a read-latency pipeline.

Parameters:
- ADDR_W, 16, BRAM address width
- DATA_W, 8, BRAM data width
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2
- MAX_BURST, 16, max consecutive granted cycles for an unlocked owner while others wait

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-requester access request
- lock  in  3  per-requester hold-grant; suppresses the burst cap
- we  in  3  per-requester write enable (1 = write, 0 = read)
- addr  in  3*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  per-requester write data, packed the same way
- gnt  out  3  one-hot grant, registered
- rvalid  out  3  one-hot read-data-valid
- rdata  out  DATA_W  shared read data; equals mem_dout
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_din  out  DATA_W  BRAM write data
- mem_dout  in  DATA_W  BRAM read data

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
  - State IDLE, burst_cnt=0, last_owner=2 (so requester 0 wins first), read tag pipeline flushed.
  - In-flight reads are discarded; no rvalid after reset release.
- States: IDLE (no owner) and OWN (owner index o held in register).
- IDLE:
  - If any req is high, pick the winner by round-robin starting at last_owner+1 (mod 3).
  - Next cycle: gnt[winner]=1, state OWN, burst_cnt=0.
  - Grant latency is 1 cycle from req to gnt.
- OWN, evaluated each cycle:
  - Release if req[o]=0.
  - Release if lock[o]=0, another req is pending, and burst_cnt=MAX_BURST-1.
  - Otherwise hold the grant and increment burst_cnt, saturating at MAX_BURST-1.
- On release:
  - last_owner=o.
  - If another req is pending, hand over directly to the next round-robin winner (excluding o): gnt[o] falls and gnt[new] rises on the same edge, no bubble, no overlap.
  - If no other req is pending, go to IDLE with gnt=0.
- Access:
  - An access happens in any cycle with gnt[o]=1 and req[o]=1.
  - mem_en=1; mem_we, mem_addr, mem_din are muxed combinationally from requester o's inputs.
  - When no access happens, mem_en=0 and mem_we=0; mem_addr and mem_din hold their last values.
- Read return:
  - Each read access pushes tag o into an RD_LAT-deep pipeline.
  - rvalid[o]=1 exactly RD_LAT cycles after the access, with rdata=mem_dout.
  - The tag survives grant handover; a read issued as the last owned cycle still returns to its issuer.
- A locked owner with req held is never preempted; starvation of the others is by design (bulk UART load).
- Simultaneous release of o and a new req from o: o is lowest round-robin priority on handover.
- Requests are level-held; dropping req without a grant is legal and has no effect.
- gnt is always one-hot or zero.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: round-robin replaced by fixed priority 0 > 1 > 2 for both IDLE pick and handover; last_owner unused. Burst cap still applies, so release goes to the highest-priority pending requester other than o.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package arb_pkg: requester index constants REQ_UART_WR=0, REQ_DS=1, REQ_UART_RD=2; NREQ=3; state encoding IDLE/OWN.
- One sub-module: rr_pick3 (combinational next-winner from a 3-bit pending mask and a base index; also serves fixed priority with base tied to 2).
- Read-tag pipeline stays inline.

Test Plan:
- Reset then req=3'b111, none locked: gnt 3'b001 for 16 cycles, then 3'b010 for 16, then 3'b100; no gap cycles, never two bits set.
- req0 locked write burst: 20 writes to addr 0x0000..0x0013, data 0xA0..0xB3, with req1 high throughout: gnt stays 3'b001 all 20 cycles; BRAM holds the data; gnt to 1 the cycle after req0 drops.
- RD_LAT=2, req2 reads addr 0x0005 (contains 0x5A) on its final granted cycle while handing over to req1: rvalid=3'b100 and rdata=0x5A two cycles later; rvalid[1] stays low.
- Single req1 alone: gnt[1] one cycle after req, held indefinitely beyond MAX_BURST; no release without contention.
- rst_n pulsed low mid-burst with a read in flight: all outputs 0 immediately; no rvalid after release; first grant goes to req0.
- ARB_FIXED_PRIO_EN defined, req=3'b110 unlocked: req1 granted; after 16 cycles handover to req2; when req2 releases with req1 pending, req1 regranted.
